// File: rtl/pong_pkg.sv
// Shared definitions for the Pong controller: game state encoding, screen
// geometry, colour codes and small span-compare helpers.
package pong_pkg;

  localparam int unsigned POS_W     = 10;  // beam / object coordinate width
  localparam int unsigned SPOS_W    = 11;  // signed next-position width
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned RGB_W     = 3;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned H_CENTRE  = 320;
  localparam int unsigned V_CENTRE  = 240;

  localparam logic [RGB_W-1:0] RGB_BLACK = 3'b000;
  localparam logic [RGB_W-1:0] RGB_WHITE = 3'b111;
  localparam logic [RGB_W-1:0] RGB_GREEN = 3'b010;
  localparam logic [RGB_W-1:0] RGB_RED   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // pos lies in [lo, lo+len); 11-bit so lo+len cannot wrap
  function automatic logic in_span(input logic [POS_W-1:0] pos,
                                   input logic [POS_W-1:0] lo,
                                   input int unsigned len);
    logic [SPOS_W-1:0] p;
    logic [SPOS_W-1:0] l;
    p = {1'b0, pos};
    l = {1'b0, lo};
    return (p >= l) && (p < l + SPOS_W'(len));
  endfunction

  // [a, a+alen) and [b, b+blen) share at least one pixel
  function automatic logic spans_overlap(input logic [POS_W-1:0] a,
                                         input int unsigned alen,
                                         input logic [POS_W-1:0] b,
                                         input int unsigned blen);
    logic [SPOS_W-1:0] a_w;
    logic [SPOS_W-1:0] b_w;
    a_w = {1'b0, a};
    b_w = {1'b0, b};
    return (a_w < b_w + SPOS_W'(blen)) && (a_w + SPOS_W'(alen) > b_w);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_pixel_mux.sv
// Per-pixel compositor: compares the beam position against ball, paddles and
// centre line and registers the resulting colour (one cycle latency).
// Ports: clock, rst (sync, active-high), active_zone, x_pos/y_pos beam position,
//        ball_x/ball_y, p1_y/p2_y object positions, state, rgb registered colour.
module pong_pixel_mux
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_H  = 64,
  parameter int unsigned PADDLE_W  = 8,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned P1_X      = 16,
  parameter int unsigned P2_X      = 616
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               active_zone,
  input  logic [POS_W-1:0]   x_pos,
  input  logic [POS_W-1:0]   y_pos,
  input  logic [POS_W-1:0]   ball_x,
  input  logic [POS_W-1:0]   ball_y,
  input  logic [POS_W-1:0]   p1_y,
  input  logic [POS_W-1:0]   p2_y,
  input  game_state_t        state,
  output logic [RGB_W-1:0]   rgb
);

  localparam logic [POS_W-1:0] P1_XP  = POS_W'(P1_X);
  localparam logic [POS_W-1:0] P2_XP  = POS_W'(P2_X);
  localparam logic [POS_W-1:0] LINE_X = POS_W'(H_CENTRE - 2);
  localparam int unsigned      LINE_W = 4;

  logic             ball_on;
  logic             ball_hit;
  logic             pad_hit;
  logic             line_hit;
  logic [RGB_W-1:0] rgb_c;

  // Layer from lowest to highest priority; later assignments win
  always_comb begin
    ball_on  = (state == ST_SERVE) || (state == ST_PLAY);
    ball_hit = ball_on && in_span(x_pos, ball_x, BALL_SIZE) && in_span(y_pos, ball_y, BALL_SIZE);
    pad_hit  = (in_span(x_pos, P1_XP, PADDLE_W) && in_span(y_pos, p1_y, PADDLE_H)) ||
               (in_span(x_pos, P2_XP, PADDLE_W) && in_span(y_pos, p2_y, PADDLE_H));
    line_hit = in_span(x_pos, LINE_X, LINE_W) && !y_pos[4];

    rgb_c = (state == ST_OVER) ? RGB_RED : RGB_BLACK;
    if (line_hit)     rgb_c = RGB_GREEN;
    if (pad_hit)      rgb_c = RGB_WHITE;
    if (ball_hit)     rgb_c = RGB_WHITE;
    if (!active_zone) rgb_c = RGB_BLACK;
  end

  always_ff @(posedge clock) begin
    if (rst) rgb <= RGB_BLACK;
    else     rgb <= rgb_c;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong controller: v_sync edge detect, game FSM, paddle/ball
// motion and scoring once per frame in vblank, plus the pixel compositor.
// Ports: clock, rst (sync, active-high), v_sync (active-low pulse), active_zone,
//        x_pos/y_pos beam, btn_start, p1_up/p1_dn, p2_up/p2_dn paddle buttons,
//        rgb colour, score_p1/score_p2, game_state (IDLE/SERVE/PLAY/OVER).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned P1_X         = 16,
  parameter int unsigned P2_X         = 616,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               v_sync,
  input  logic               active_zone,
  input  logic [POS_W-1:0]   x_pos,
  input  logic [POS_W-1:0]   y_pos,
  input  logic               btn_start,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  output logic [RGB_W-1:0]   rgb,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         game_state
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [POS_W-1:0]         BALL_X0    = POS_W'(H_CENTRE - BALL_SIZE / 2);
  localparam logic [POS_W-1:0]         BALL_Y0    = POS_W'(V_CENTRE - BALL_SIZE / 2);
  localparam logic [POS_W-1:0]         PAD_Y0     = POS_W'(V_CENTRE - PADDLE_H / 2);
  localparam logic signed [SPOS_W-1:0] ZERO_S     = '0;
  localparam logic signed [SPOS_W-1:0] PAD_Y_MAX  = SPOS_W'(V_VISIBLE - PADDLE_H);
  localparam logic signed [SPOS_W-1:0] BALL_Y_MAX = SPOS_W'(V_VISIBLE - BALL_SIZE);
  localparam logic signed [SPOS_W-1:0] BALL_X_MAX = SPOS_W'(H_VISIBLE - BALL_SIZE);
  localparam logic signed [SPOS_W-1:0] HIT_L_X    = SPOS_W'(P1_X + PADDLE_W);
  localparam logic signed [SPOS_W-1:0] HIT_R_X    = SPOS_W'(P2_X - BALL_SIZE);
  localparam logic signed [SPOS_W-1:0] PAD_STEP   = SPOS_W'(PADDLE_SPEED);
  localparam logic signed [SPOS_W-1:0] BALL_STEP  = SPOS_W'(BALL_SPEED);
  localparam logic [SCORE_W-1:0]       WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]         SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  game_state_t         state;
  logic [POS_W-1:0]    p1_y;
  logic [POS_W-1:0]    p2_y;
  logic [POS_W-1:0]    ball_x;
  logic [POS_W-1:0]    ball_y;
  logic                dx;          // 1 = moving right
  logic                dy;          // 1 = moving down
  logic [CNT_W-1:0]    serve_cnt;
  logic                vs_q;
  logic                frame_tick;

  logic [POS_W-1:0]         p1_nxt;
  logic [POS_W-1:0]         p2_nxt;
  logic signed [SPOS_W-1:0] nx;
  logic signed [SPOS_W-1:0] ny;
  logic                     hit_l;
  logic                     hit_r;
  logic                     miss_l;
  logic                     miss_r;
  logic [SCORE_W-1:0]       s1_inc;
  logic [SCORE_W-1:0]       s2_inc;

  // One paddle step with clamp; signed so moving up from y<speed clamps to 0
  function automatic logic [POS_W-1:0] paddle_step(input logic [POS_W-1:0] y,
                                                   input logic up, input logic dn);
    logic signed [SPOS_W-1:0] t;
    t = $signed({1'b0, y});
    if (up && !dn)      t = t - PAD_STEP;
    else if (dn && !up) t = t + PAD_STEP;
    if (t < ZERO_S)         t = ZERO_S;
    else if (t > PAD_Y_MAX) t = PAD_Y_MAX;
    return t[POS_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s < WIN) ? s + SCORE_W'(1) : s;
  endfunction

  // Next-frame candidates; hit/miss use the pre-update ball and paddle spans
  always_comb begin
    p1_nxt = paddle_step(p1_y, p1_up, p1_dn);
    p2_nxt = paddle_step(p2_y, p2_up, p2_dn);
    nx     = dx ? $signed({1'b0, ball_x}) + BALL_STEP : $signed({1'b0, ball_x}) - BALL_STEP;
    ny     = dy ? $signed({1'b0, ball_y}) + BALL_STEP : $signed({1'b0, ball_y}) - BALL_STEP;
    hit_l  = !dx && (nx <= HIT_L_X) && spans_overlap(ball_y, BALL_SIZE, p1_y, PADDLE_H);
    hit_r  =  dx && (nx >= HIT_R_X) && spans_overlap(ball_y, BALL_SIZE, p2_y, PADDLE_H);
    miss_l = !hit_l && (nx <= ZERO_S);
    miss_r = !hit_r && (nx >= BALL_X_MAX);
    s1_inc = sat_inc(score_p1);
    s2_inc = sat_inc(score_p2);
  end

  // Game FSM and object registers; motion only on frame_tick (inside vblank)
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_IDLE;
      score_p1   <= '0;
      score_p2   <= '0;
      p1_y       <= PAD_Y0;
      p2_y       <= PAD_Y0;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      serve_cnt  <= '0;
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= v_sync;
      frame_tick <= vs_q & ~v_sync;

      if (frame_tick && (state != ST_IDLE)) begin
        p1_y <= p1_nxt;
        p2_y <= p2_nxt;
      end

      case (state)
        ST_IDLE: begin
          if (btn_start) begin
            state     <= ST_SERVE;
            serve_cnt <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
          end
        end

        ST_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              state     <= ST_PLAY;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + CNT_W'(1);
            end
          end
        end

        ST_PLAY: begin
          if (frame_tick) begin
            if (ny <= ZERO_S) begin
              ball_y <= '0;
              dy     <= 1'b1;
            end else if (ny >= BALL_Y_MAX) begin
              ball_y <= BALL_Y_MAX[POS_W-1:0];
              dy     <= 1'b0;
            end else begin
              ball_y <= ny[POS_W-1:0];
            end

            if (hit_l) begin
              ball_x <= HIT_L_X[POS_W-1:0];
              dx     <= 1'b1;
            end else if (hit_r) begin
              ball_x <= HIT_R_X[POS_W-1:0];
              dx     <= 1'b0;
            end else if (miss_l || miss_r) begin
              // recentre; the next serve heads toward the player who just scored
              ball_x    <= BALL_X0;
              ball_y    <= BALL_Y0;
              dx        <= miss_l;
              serve_cnt <= '0;
              if (miss_l) begin
                score_p2 <= s2_inc;
                state    <= (s2_inc == WIN) ? ST_OVER : ST_SERVE;
              end else begin
                score_p1 <= s1_inc;
                state    <= (s1_inc == WIN) ? ST_OVER : ST_SERVE;
              end
            end else begin
              ball_x <= nx[POS_W-1:0];
            end
          end
        end

        ST_OVER: begin
          if (btn_start) begin
            score_p1  <= '0;
            score_p2  <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            serve_cnt <= '0;
            state     <= ST_SERVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_state = state;

  pong_pixel_mux #(
    .PADDLE_H  (PADDLE_H),
    .PADDLE_W  (PADDLE_W),
    .BALL_SIZE (BALL_SIZE),
    .P1_X      (P1_X),
    .P2_X      (P2_X)
  ) u_pixel_mux (
    .clock       (clock),
    .rst         (rst),
    .active_zone (active_zone),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .p1_y        (p1_y),
    .p2_y        (p2_y),
    .state       (state),
    .rgb         (rgb)
  );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: short synthetic frames, a frame-level game model
// kept in plain integers, and pixel probes against a geometric colour model.
module tb_pong_game_ctrl;

  logic       clock = 1'b0;
  logic       rst, v_sync, active_zone, btn_start;
  logic       p1_up, p1_dn, p2_up, p2_dn;
  logic [9:0] x_pos, y_pos;
  logic [2:0] rgb;
  logic [3:0] score_p1, score_p2;
  logic [1:0] game_state;

  int total = 0;
  int bad   = 0;

  // model: state 0..3, positions in px, velocities as signed px/frame
  int m_state, m_s1, m_s2, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_serve;

  always #20 clock = ~clock;

  pong_game_ctrl dut (
    .clock(clock), .rst(rst), .v_sync(v_sync), .active_zone(active_zone),
    .x_pos(x_pos), .y_pos(y_pos), .btn_start(btn_start),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .rgb(rgb), .score_p1(score_p1), .score_p2(score_p2), .game_state(game_state)
  );

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit overlap(int by, int py);
    return (by < py + 64) && (by + 8 > py);
  endfunction

  function automatic logic [2:0] exp_rgb(int x, int y, bit act);
    bit ball_vis = (m_state == 1) || (m_state == 2);
    if (!act) return 3'b000;
    if (ball_vis && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 3'b111;
    if (x >= 16 && x < 24 && y >= m_p1 && y < m_p1 + 64) return 3'b111;
    if (x >= 616 && x < 624 && y >= m_p2 && y < m_p2 + 64) return 3'b111;
    if (x >= 318 && x <= 321 && ((y / 16) % 2 == 0)) return 3'b010;
    return (m_state == 3) ? 3'b100 : 3'b000;
  endfunction

  task automatic model_reset();
    m_state = 0; m_s1 = 0; m_s2 = 0; m_p1 = 208; m_p2 = 208;
    m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2; m_serve = 0;
  endtask

  task automatic model_start();
    if (m_state == 3) begin m_s1 = 0; m_s2 = 0; end
    if (m_state == 0 || m_state == 3) begin
      m_bx = 316; m_by = 236; m_serve = 0; m_state = 1;
    end
  endtask

  // one frame of game rules
  task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2);
    int op1, op2, nx, ny, scorer;
    op1 = m_p1; op2 = m_p2;
    if (m_state != 0) begin
      m_p1 = clampi(m_p1 + 4 * (int'(d1) - int'(u1)), 0, 416);
      m_p2 = clampi(m_p2 + 4 * (int'(d2) - int'(u2)), 0, 416);
    end
    if (m_state == 1) begin
      m_serve++;
      if (m_serve == 60) begin m_state = 2; m_serve = 0; end
    end else if (m_state == 2) begin
      nx = m_bx + m_vx; ny = m_by + m_vy; scorer = 0;
      if (ny <= 0) begin ny = 0; m_vy = 2; end
      else if (ny >= 472) begin ny = 472; m_vy = -2; end
      if (m_vx < 0 && nx <= 24 && overlap(m_by, op1)) begin nx = 24; m_vx = 2; end
      else if (m_vx > 0 && nx >= 608 && overlap(m_by, op2)) begin nx = 608; m_vx = -2; end
      else if (nx <= 0) scorer = 2;
      else if (nx >= 632) scorer = 1;
      if (scorer == 0) begin
        m_bx = nx; m_by = ny;
      end else begin
        if (scorer == 1) m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
        else             m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
        m_bx = 316; m_by = 236; m_serve = 0;
        m_vx = (scorer == 2) ? 2 : -2;
        m_state = (m_s1 == 9 || m_s2 == 9) ? 3 : 1;
      end
    end
  endtask

  // v_sync low for one cycle, buttons held; the update lands two edges later
  task automatic drive_frame(input bit u1, input bit d1, input bit u2, input bit d2);
    @(negedge clock);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; v_sync = 1'b0;
    @(negedge clock);
    v_sync = 1'b1;
    @(negedge clock);
    model_tick(u1, d1, u2, d2);
  endtask

  task automatic pulse_start();
    @(negedge clock); btn_start = 1'b1;
    @(negedge clock); btn_start = 1'b0;
    model_start();
  endtask

  task automatic probe(input int x, input int y, input bit act, output logic [2:0] got);
    @(negedge clock);
    x_pos = 10'(x); y_pos = 10'(y); active_zone = act;
    @(negedge clock);
    got = rgb;
    active_zone = 1'b0; x_pos = '0; y_pos = '0;
  endtask

  // steering: {up,dn}; track follows the ball, away avoids it
  function automatic bit [1:0] steer(int p, int by, bit away);
    int pc = p + 32;
    int bc = by + 4;
    if (away) return (bc < 240) ? 2'b01 : 2'b10;
    if (pc < bc - 4) return 2'b01;
    if (pc > bc + 4) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    @(negedge clock); v_sync = 1'b0;
    @(negedge clock); v_sync = 1'b1; rst = 1'b1;
    @(negedge clock);
    @(negedge clock); rst = 1'b0;
    model_reset();
    @(negedge clock);
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", game_state); end
    total++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_p1, score_p2); end
    total++; if (rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
    total++; if (dut.ball_x !== 10'd316 || dut.ball_y !== 10'd236) begin bad++; $display("FAIL reset_ball got=(%0d,%0d) exp=(316,236)", dut.ball_x, dut.ball_y); end
    total++; if (dut.p1_y !== 10'd208 || dut.p2_y !== 10'd208) begin bad++; $display("FAIL reset_paddles got=%0d/%0d exp=208/208", dut.p1_y, dut.p2_y); end
    total++; if (dut.dx !== 1'b1) begin bad++; $display("FAIL reset_dx got=%b exp=1", dut.dx); end
  endtask

  task automatic test_serve();
    drive_frame(1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (dut.p1_y !== 10'd208 || dut.p2_y !== 10'd208) begin bad++; $display("FAIL idle_paddles got=%0d/%0d exp=208/208", dut.p1_y, dut.p2_y); end
    pulse_start();
    total++; if (game_state !== 2'd1) begin bad++; $display("FAIL start_serve got=%0d exp=1", game_state); end
    for (int i = 1; i <= 60; i++) begin
      drive_frame(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 59) begin
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL serve_59 got=%0d exp=1", game_state); end
      end
      if (i == 60) begin
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL serve_60 got=%0d exp=2", game_state); end
      end
    end
    drive_frame(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (dut.ball_x !== 10'd318 || dut.ball_y !== 10'd238) begin bad++; $display("FAIL first_move got=(%0d,%0d) exp=(318,238)", dut.ball_x, dut.ball_y); end
  endtask

  task automatic test_paddles();
    for (int i = 0; i < 54; i++) begin
      drive_frame(1'b1, 1'b0, 1'b0, 1'b1);
      total++; if (dut.p1_y !== 10'(m_p1) || dut.p2_y !== 10'(m_p2)) begin bad++; $display("FAIL paddle_step i=%0d got=%0d/%0d exp=%0d/%0d", i, dut.p1_y, dut.p2_y, m_p1, m_p2); end
    end
    total++; if (dut.p1_y !== 10'd0 || dut.p2_y !== 10'd416) begin bad++; $display("FAIL paddle_clamp got=%0d/%0d exp=0/416", dut.p1_y, dut.p2_y); end
    for (int i = 0; i < 3; i++) drive_frame(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (dut.p1_y !== 10'd0 || dut.p2_y !== 10'd416) begin bad++; $display("FAIL paddle_both got=%0d/%0d exp=0/416", dut.p1_y, dut.p2_y); end
    total++; if (dut.ball_x !== 10'(m_bx) || dut.ball_y !== 10'(m_by)) begin bad++; $display("FAIL paddle_ball got=(%0d,%0d) exp=(%0d,%0d)", dut.ball_x, dut.ball_y, m_bx, m_by); end
  endtask

  task automatic test_rally();
    logic [2:0] got;
    int f;
    f = 0;
    while (f < 7000 && m_state != 3) begin
      bit [1:0] b1, b2;
      int px, py;
      if (f < 700) begin
        b1 = steer(m_p1, m_by, 1'b0); b2 = steer(m_p2, m_by, 1'b0);
      end else if (f < 1100) begin
        b1 = 2'($urandom_range(0, 3)); b2 = 2'($urandom_range(0, 3));
      end else begin
        b1 = steer(m_p1, m_by, 1'b1); b2 = steer(m_p2, m_by, 1'b1);
      end
      drive_frame(b1[1], b1[0], b2[1], b2[0]);
      total++; if (game_state !== 2'(m_state)) begin bad++; $display("FAIL rally_state f=%0d got=%0d exp=%0d", f, game_state, m_state); end
      total++; if (score_p1 !== 4'(m_s1) || score_p2 !== 4'(m_s2)) begin bad++; $display("FAIL rally_score f=%0d got=%0d/%0d exp=%0d/%0d", f, score_p1, score_p2, m_s1, m_s2); end
      total++; if (dut.ball_x !== 10'(m_bx) || dut.ball_y !== 10'(m_by)) begin bad++; $display("FAIL rally_ball f=%0d got=(%0d,%0d) exp=(%0d,%0d)", f, dut.ball_x, dut.ball_y, m_bx, m_by); end
      total++; if (dut.p1_y !== 10'(m_p1) || dut.p2_y !== 10'(m_p2)) begin bad++; $display("FAIL rally_paddle f=%0d got=%0d/%0d exp=%0d/%0d", f, dut.p1_y, dut.p2_y, m_p1, m_p2); end
      total++; if (dut.dx !== (m_vx > 0)) begin bad++; $display("FAIL rally_dx f=%0d got=%b exp=%b", f, dut.dx, (m_vx > 0)); end
      if (f % 16 == 0) begin
        if (f % 32 == 0) begin px = m_bx + 3; py = m_by + 5; end
        else begin px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479)); end
        probe(px, py, 1'b1, got);
        total++; if (got !== exp_rgb(px, py, 1'b1)) begin bad++; $display("FAIL rally_pixel (%0d,%0d) got=%b exp=%b", px, py, got, exp_rgb(px, py, 1'b1)); end
      end
      f++;
    end
    total++; if (m_state != 3) begin bad++; $display("FAIL rally_end got_state=%0d exp=3 frames=%0d", game_state, f); end
  endtask

  task automatic test_over();
    logic [2:0] got;
    total++; if (game_state !== 2'd3) begin bad++; $display("FAIL over_state got=%0d exp=3", game_state); end
    total++; if (!((score_p1 === 4'd9) ^ (score_p2 === 4'd9))) begin bad++; $display("FAIL over_winner got=%0d/%0d exp=one at 9", score_p1, score_p2); end
    probe(100, 100, 1'b1, got);
    total++; if (got !== 3'b100) begin bad++; $display("FAIL over_bg got=%b exp=100", got); end
    probe(316, 237, 1'b1, got);
    total++; if (got !== 3'b100) begin bad++; $display("FAIL over_ball_hidden got=%b exp=100", got); end
    drive_frame(1'b0, 1'b1, 1'b1, 1'b0);
    total++; if (score_p1 !== 4'(m_s1) || score_p2 !== 4'(m_s2) || game_state !== 2'd3) begin bad++; $display("FAIL over_frozen got=%0d/%0d st=%0d exp=%0d/%0d st=3", score_p1, score_p2, game_state, m_s1, m_s2); end
    total++; if (dut.p1_y !== 10'(m_p1) || dut.p2_y !== 10'(m_p2)) begin bad++; $display("FAIL over_paddle got=%0d/%0d exp=%0d/%0d", dut.p1_y, dut.p2_y, m_p1, m_p2); end
    pulse_start();
    total++; if (game_state !== 2'd1 || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin bad++; $display("FAIL restart got st=%0d %0d/%0d exp st=1 0/0", game_state, score_p1, score_p2); end
    total++; if (dut.ball_x !== 10'd316 || dut.ball_y !== 10'd236) begin bad++; $display("FAIL restart_ball got=(%0d,%0d) exp=(316,236)", dut.ball_x, dut.ball_y); end
  endtask

  task automatic test_pixel();
    logic [2:0] got;
    int xs[8];
    int ys[8];
    bit as[8];
    xs = '{16, 623, 16, 319, 319, 316, 15, 24};
    ys = '{m_p1, m_p2 + 63, m_p1, 0, 16, 236, m_p1, m_p1};
    as = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      probe(xs[i], ys[i], as[i], got);
      total++; if (got !== exp_rgb(xs[i], ys[i], as[i])) begin bad++; $display("FAIL pixel_%0d (%0d,%0d,a=%0d) got=%b exp=%b", i, xs[i], ys[i], as[i], got, exp_rgb(xs[i], ys[i], as[i])); end
    end
    probe(16, m_p1, 1'b1, got);
    total++; if (got !== 3'b111) begin bad++; $display("FAIL pixel_paddle got=%b exp=111", got); end
    probe(319, 0, 1'b1, got);
    total++; if (got !== 3'b010) begin bad++; $display("FAIL pixel_line got=%b exp=010", got); end
  endtask

  initial begin
    rst = 1'b1; v_sync = 1'b1; active_zone = 1'b0; btn_start = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    x_pos = '0; y_pos = '0;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    model_reset();
    test_reset();
    test_serve();
    test_paddles();
    test_rally();
    test_over();
    for (int i = 0; i < 5; i++) drive_frame(1'b0, 1'b1, 1'b1, 1'b0);
    test_pixel();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
